// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared FSM states, redirect sources and default vectors for pc_seq
package pc_seq_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h00400000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h00400004;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_FLUSH
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_JR,
    SRC_ERET,
    SRC_EXC
  } src_e;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - redirect request / PC write bundle between pipeline (master) and pc_seq (slave)
interface pc_seq_if;
  logic [31:0] pc_cur;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        jmp_i;
  logic [31:0] jmp_target_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        exc_i;
  logic [31:0] pc_next_o;
  logic        pc_we_o;
  logic        flush_o;
  logic        pend_o;
  logic        addr_err_o;

  modport master (
    output pc_cur, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
           jr_i, jr_target_i, eret_i, epc_i, exc_i,
    input  pc_next_o, pc_we_o, flush_o, pend_o, addr_err_o
  );

  modport slave (
    input  pc_cur, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
           jr_i, jr_target_i, eret_i, epc_i, exc_i,
    output pc_next_o, pc_we_o, flush_o, pend_o, addr_err_o
  );
endinterface

// File: rtl/pc_seq_target_mux.sv
// rtl/pc_seq_target_mux.sv - combinational priority selector of redirect targets
// PC_SEQ_MISALIGN_TRAP_EN: misaligned non-exception targets become EXC_VECTOR and raise trap_o.
module pc_target_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic        jr_i,
  input  logic        jmp_i,
  input  logic        br_taken_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] jr_target_i,
  input  logic [31:0] jmp_target_i,
  input  logic [31:0] br_target_i,
  output logic        valid_o,
  output src_e        src_o,
  output logic [31:0] target_o,
  output logic        trap_o
);

  logic [31:0] raw;

  always_comb begin
    valid_o = 1'b1;
    src_o   = SRC_SEQ;
    raw     = '0;
    if (exc_i) begin
      src_o = SRC_EXC;
      raw   = EXC_VECTOR;
    end else if (eret_i) begin
      src_o = SRC_ERET;
      raw   = epc_i;
    end else if (jr_i) begin
      src_o = SRC_JR;
      raw   = jr_target_i;
    end else if (jmp_i) begin
      src_o = SRC_JMP;
      raw   = jmp_target_i;
    end else if (br_taken_i) begin
      src_o = SRC_BR;
      raw   = br_target_i;
    end else begin
      valid_o = 1'b0;
    end
  end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  always_comb begin
    trap_o   = valid_o && (src_o != SRC_EXC) && (raw[1:0] != 2'b00);
    target_o = trap_o ? EXC_VECTOR : raw;
  end
`else
  assign trap_o   = 1'b0;
  assign target_o = raw & ~32'h3;
`endif

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - next-PC sequencer: redirect arbitration, stall-held redirect, IF/ID flush pulse
// PC_SEQ_MISALIGN_TRAP_EN enables the misaligned-target trap and addr_err_o.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic       clk,
  input logic       rst,
  pc_seq_if.slave   bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_trap_q, pend_trap_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        addr_err_q, addr_err_d;

  logic        sel_valid;
  src_e        sel_src;
  logic [31:0] sel_target;
  logic        sel_trap;
  logic        pc_we_c;
  logic [31:0] pc_next_c;

  pc_target_mux #(.EXC_VECTOR(EXC_VECTOR)) u_mux (
    .exc_i        (bus.exc_i),
    .eret_i       (bus.eret_i),
    .jr_i         (bus.jr_i),
    .jmp_i        (bus.jmp_i),
    .br_taken_i   (bus.br_taken_i),
    .epc_i        (bus.epc_i),
    .jr_target_i  (bus.jr_target_i),
    .jmp_target_i (bus.jmp_target_i),
    .br_target_i  (bus.br_target_i),
    .valid_o      (sel_valid),
    .src_o        (sel_src),
    .target_o     (sel_target),
    .trap_o       (sel_trap)
  );

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_trap_d  = pend_trap_q;
    cnt_d        = cnt_q;
    flush_d      = 1'b0;
    addr_err_d   = 1'b0;
    pc_we_c      = 1'b0;
    pc_next_c    = bus.pc_cur;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;

      ST_RUN: begin
        if (sel_valid && sel_src == SRC_EXC) begin
          pc_we_c   = 1'b1;
          pc_next_c = sel_target;
          state_d   = ST_FLUSH;
          cnt_d     = FLUSH_LOAD;
          flush_d   = 1'b1;
        end else if (sel_valid && bus.stall_i) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = sel_target;
          pend_trap_d  = sel_trap;
          state_d      = ST_HOLD;
        end else if (sel_valid) begin
          pc_we_c    = 1'b1;
          pc_next_c  = sel_target;
          addr_err_d = sel_trap;
          state_d    = ST_FLUSH;
          cnt_d      = FLUSH_LOAD;
          flush_d    = 1'b1;
        end else if (!bus.stall_i) begin
          pc_we_c   = 1'b1;
          pc_next_c = seq_pc(bus.pc_cur);
        end
      end

      // Newer non-exception redirects are dropped: the held one is older in program order.
      ST_HOLD: begin
        if (sel_valid && sel_src == SRC_EXC) begin
          pc_we_c      = 1'b1;
          pc_next_c    = sel_target;
          pend_valid_d = 1'b0;
          pend_trap_d  = 1'b0;
          state_d      = ST_FLUSH;
          cnt_d        = FLUSH_LOAD;
          flush_d      = 1'b1;
        end else if (!bus.stall_i) begin
          pc_we_c      = 1'b1;
          pc_next_c    = pend_pc_q;
          addr_err_d   = pend_trap_q;
          pend_valid_d = 1'b0;
          pend_trap_d  = 1'b0;
          state_d      = ST_FLUSH;
          cnt_d        = FLUSH_LOAD;
          flush_d      = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (sel_valid && sel_src == SRC_EXC) begin
          pc_we_c   = 1'b1;
          pc_next_c = sel_target;
          cnt_d     = FLUSH_LOAD;
          flush_d   = 1'b1;
        end else begin
          if (!bus.stall_i) begin
            pc_we_c   = 1'b1;
            pc_next_c = seq_pc(bus.pc_cur);
          end
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = ST_RUN;
          end else begin
            cnt_d   = cnt_q - 2'd1;
            flush_d = 1'b1;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pend_trap_q  <= 1'b0;
      cnt_q        <= 2'd0;
      flush_q      <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_trap_q  <= pend_trap_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.pc_we_o    = rst ? pc_we_c : 1'b0;
  assign bus.pc_next_o  = rst ? pc_next_c : RESET_PC;
  assign bus.flush_o    = flush_q;
  assign bus.pend_o     = pend_valid_q;
  assign bus.addr_err_o = addr_err_q;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed plan cases plus randomized run against a rule-level next-PC model
module tb_pc_seq;
  localparam logic [31:0] RST_PC = 32'h00400000;
  localparam logic [31:0] EXC_PC = 32'h00400004;
  localparam int          FC     = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_seq_if bus();

  pc_seq #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Model state: booting, held redirect, remaining flush cycles, pending addr_err pulse.
  bit          m_boot;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  bit          m_pend_trap;
  int          m_fl;
  bit          m_aerr;

  logic        obs_we, obs_flush, obs_pend, obs_aerr;
  logic [31:0] obs_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pick(input bit ex, er, jr, jm, br,
                      input logic [31:0] et, jt, jmt, bt,
                      output bit has, output logic [31:0] t, output bit trap);
    has  = 1'b1;
    trap = 1'b0;
    if (ex)      t = EXC_PC;
    else if (er) t = et;
    else if (jr) t = jt;
    else if (jm) t = jmt;
    else if (br) t = bt;
    else begin
      has = 1'b0;
      t   = '0;
    end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    if (has && !ex && t[1:0] != 2'b00) begin
      t    = EXC_PC;
      trap = 1'b1;
    end
`else
    t[1:0] = 2'b00;
`endif
  endtask

  task automatic cycle(input bit r, st, ex, er, jr, jm, br,
                       input logic [31:0] pc, et, jt, jmt, bt);
    bit          ewe, has, trap, aerr_n;
    logic [31:0] enext, t;
    rst              = r;
    bus.pc_cur       = pc;
    bus.stall_i      = st;
    bus.exc_i        = ex;
    bus.eret_i       = er;
    bus.jr_i         = jr;
    bus.jmp_i        = jm;
    bus.br_taken_i   = br;
    bus.epc_i        = et;
    bus.jr_target_i  = jt;
    bus.jmp_target_i = jmt;
    bus.br_target_i  = bt;
    @(negedge clk);
    obs_we    = bus.pc_we_o;
    obs_next  = bus.pc_next_o;
    obs_flush = bus.flush_o;
    obs_pend  = bus.pend_o;
    obs_aerr  = bus.addr_err_o;

    pick(ex, er, jr, jm, br, et, jt, jmt, bt, has, t, trap);
    ewe   = 1'b0;
    enext = RST_PC;
    if (!r || m_boot) ewe = 1'b0;
    else if (ex) begin ewe = 1'b1; enext = EXC_PC; end
    else if (m_fl > 0) begin if (!st) begin ewe = 1'b1; enext = pc + 32'd4; end end
    else if (m_pend) begin if (!st) begin ewe = 1'b1; enext = m_pend_pc; end end
    else if (has) begin if (!st) begin ewe = 1'b1; enext = t; end end
    else if (!st) begin ewe = 1'b1; enext = pc + 32'd4; end

    check("pc_we", {31'd0, obs_we}, {31'd0, ewe});
    if (ewe || !r) check("pc_next", obs_next, enext);
    check("flush", {31'd0, obs_flush}, {31'd0, m_fl > 0});
    check("pend", {31'd0, obs_pend}, {31'd0, m_pend});
    check("addr_err", {31'd0, obs_aerr}, {31'd0, m_aerr});

    aerr_n = 1'b0;
    if (!r) begin
      m_boot = 1'b1; m_pend = 1'b0; m_pend_trap = 1'b0; m_fl = 0;
    end else if (m_boot) m_boot = 1'b0;
    else if (ex) begin m_pend = 1'b0; m_pend_trap = 1'b0; m_fl = FC; end
    else if (m_fl > 0) m_fl--;
    else if (m_pend) begin
      if (!st) begin aerr_n = m_pend_trap; m_pend = 1'b0; m_pend_trap = 1'b0; m_fl = FC; end
    end else if (has) begin
      if (st) begin m_pend = 1'b1; m_pend_pc = t; m_pend_trap = trap; end
      else begin aerr_n = trap; m_fl = FC; end
    end
    m_aerr = aerr_n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit st, input logic [31:0] pc);
    cycle(1'b1, st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pc, '0, '0, '0, '0);
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] v;
    v = $urandom();
    if ($urandom_range(3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    bus.pc_cur = '0; bus.stall_i = 0; bus.exc_i = 0; bus.eret_i = 0; bus.jr_i = 0;
    bus.jmp_i = 0; bus.br_taken_i = 0; bus.epc_i = '0; bus.jr_target_i = '0;
    bus.jmp_target_i = '0; bus.br_target_i = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_boot = 1'b1; m_pend = 1'b0; m_pend_pc = '0; m_pend_trap = 1'b0; m_fl = 0; m_aerr = 1'b0;

    cycle(1'b0, 0, 0, 0, 0, 0, 0, 32'h0, '0, '0, '0, '0);
    check("rst_we", {31'd0, obs_we}, 32'd0);
    check("rst_next", obs_next, 32'h00400000);
    idle(1'b0, 32'h00400000);
    check("boot_we", {31'd0, obs_we}, 32'd0);
    idle(1'b0, 32'h00400000);
    check("first_seq", obs_next, 32'h00400004);
    check("first_we", {31'd0, obs_we}, 32'd1);

    cycle(1'b1, 0, 0, 0, 0, 0, 1, 32'h00400010, '0, '0, '0, 32'h00400040);
    check("br_next", obs_next, 32'h00400040);
    idle(1'b0, 32'h00400040);
    check("br_flush", {31'd0, obs_flush}, 32'd1);
    idle(1'b0, 32'h00400044);
    check("br_flush_end", {31'd0, obs_flush}, 32'd0);

    cycle(1'b1, 1, 0, 0, 0, 1, 0, 32'h00400048, '0, '0, 32'h00400100, '0);
    check("stall1_we", {31'd0, obs_we}, 32'd0);
    idle(1'b1, 32'h00400048);
    check("stall2_pend", {31'd0, obs_pend}, 32'd1);
    idle(1'b1, 32'h00400048);
    check("stall3_we", {31'd0, obs_we}, 32'd0);
    idle(1'b0, 32'h00400048);
    check("held_next", obs_next, 32'h00400100);
    idle(1'b0, 32'h00400100);
    check("held_pend_clr", {31'd0, obs_pend}, 32'd0);

    cycle(1'b1, 1, 1, 0, 1, 0, 1, 32'h00400104, '0, 32'h00400200, '0, 32'h00400300);
    check("exc_next", obs_next, 32'h00400004);
    check("exc_we", {31'd0, obs_we}, 32'd1);
    idle(1'b0, 32'h00400004);
    check("exc_pend", {31'd0, obs_pend}, 32'd0);

    idle(1'b0, 32'hFFFFFFFC);
    check("wrap", obs_next, 32'h00000000);

    cycle(1'b1, 0, 0, 0, 1, 0, 0, 32'h00400010, '0, 32'h00400102, '0, '0);
    idle(1'b0, 32'h00400100);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    check("mis_aerr", {31'd0, obs_aerr}, 32'd1);
`else
    check("mis_aerr", {31'd0, obs_aerr}, 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom();
      pc[1:0] = 2'b00;
      if ($urandom_range(15) == 0) pc = 32'hFFFFFFFC;
      cycle($urandom_range(63) != 0, $urandom_range(9) < 3, $urandom_range(19) == 0,
            $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
            $urandom_range(6) == 0, pc, rnd_tgt(), rnd_tgt(), rnd_tgt(), rnd_tgt());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
